// File: rtl/draw_pkg.sv
// Shared drawing definitions: FSM state encoding, default screen and bus
// geometry, and named 3-bit colours.
package draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;
  localparam int DEF_ADDR_W   = 19;
  localparam int DEF_COLOR_W  = 3;
  localparam int DEF_DIM_W    = 10;

  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/rect_addr_gen.sv
// Rectangle address generator: column/row counters and running row base.
// Optional macro RECT_FILL_CLIP_EN enables the off-screen pixel compare.
// Ports:
//   clock, resetn    clock and async active-low reset
//   load             start a new rectangle at (x_in, y_in)
//   advance          step to the next pixel
//   x_in, y_in       origin, used only on load
//   w_q, h_q         latched rectangle size
//   addr             framebuffer address of the current pixel
//   pix_valid        current pixel is on screen (always 1 without clipping)
//   last_pix         current pixel is the last of the rectangle
module rect_addr_gen import draw_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DIM_W    = DEF_DIM_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic              advance,
  input  logic [DIM_W-1:0]  x_in,
  input  logic [DIM_W-1:0]  y_in,
  input  logic [DIM_W-1:0]  w_q,
  input  logic [DIM_W-1:0]  h_q,
  output logic [ADDR_W-1:0] addr,
  output logic              pix_valid,
  output logic              last_pix
);

  if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
    $error("rect_addr_gen: screen dimensions must be positive");
  end

  logic [DIM_W-1:0]  col, row;
  logic [ADDR_W-1:0] row_base;
  logic              col_last, row_last;

  assign col_last = (col == w_q - DIM_W'(1));
  assign row_last = (row == h_q - DIM_W'(1));
  assign last_pix = col_last && row_last;
  assign addr     = row_base + ADDR_W'(col);

  // Only the low ADDR_W bits of y*SCREEN_W + x matter, so the multiply is
  // done directly at address width.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      row_base <= ADDR_W'(y_in) * ADDR_W'(SCREEN_W) + ADDR_W'(x_in);
    end else if (advance) begin
      if (col_last) begin
        col      <= '0;
        row      <= row + DIM_W'(1);
        row_base <= row_base + ADDR_W'(SCREEN_W);
      end else begin
        col <= col + DIM_W'(1);
      end
    end
  end

`ifdef RECT_FILL_CLIP_EN
  // Screen coordinates tracked alongside col/row, one bit wider so the
  // sum cannot overflow before the compare.
  logic [DIM_W:0]   px, py;
  logic [DIM_W-1:0] x_start;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px      <= '0;
      py      <= '0;
      x_start <= '0;
    end else if (load) begin
      px      <= {1'b0, x_in};
      py      <= {1'b0, y_in};
      x_start <= x_in;
    end else if (advance) begin
      if (col_last) begin
        px <= {1'b0, x_start};
        py <= py + (DIM_W+1)'(1);
      end else begin
        px <= px + (DIM_W+1)'(1);
      end
    end
  end

  assign pix_valid = (px < (DIM_W+1)'(SCREEN_W)) && (py < (DIM_W+1)'(SCREEN_H));
`else
  assign pix_valid = 1'b1;
`endif

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: writes a WxH block of one colour into the
// framebuffer, one pixel per accepted write, with start/busy/done handshake.
// Optional macro RECT_FILL_CLIP_EN suppresses writes to off-screen pixels.
// Ports:
//   clock, resetn    clock and async active-low reset
//   start            fill request, sampled only when idle
//   x, y, w, h       origin and size, latched on accepted start
//   color            fill colour, latched on accepted start
//   busy             fill in progress
//   done             one-cycle pulse at end of fill
//   mem_waddr/wdata  framebuffer write address/data
//   mem_wenable      write strobe; accepted when mem_ready is high
//   mem_ready        framebuffer write accept
//
// state | meaning
// IDLE  | waiting for start
// DRAW  | presenting pixels, advancing on accept (or clipped pixel)
// DONE  | one-cycle done pulse
module rect_fill_engine import draw_pkg::*; #(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int DIM_W    = DEF_DIM_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [DIM_W-1:0]   x,
  input  logic [DIM_W-1:0]   y,
  input  logic [DIM_W-1:0]   w,
  input  logic [DIM_W-1:0]   h,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_wenable,
  input  logic               mem_ready
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_DRAW = ST_DRAW;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]         state;
  logic [DIM_W-1:0]   w_q, h_q;
  logic [COLOR_W-1:0] color_q;
  logic               load, advance, pix_valid, last_pix;
  logic [ADDR_W-1:0]  addr;

  assign busy        = (state == S_DRAW);
  assign done        = (state == S_DONE);
  assign load        = (state == S_IDLE) && start;
  // Clipped pixels step on without waiting for the framebuffer.
  assign advance     = busy && (mem_ready || !pix_valid);
  assign mem_wenable = busy && pix_valid;
  assign mem_waddr   = busy ? addr : '0;
  assign mem_wdata   = color_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          w_q     <= w;
          h_q     <= h;
          color_q <= color;
          state   <= (w == '0 || h == '0) ? S_DONE : S_DRAW;
        end
        S_DRAW: if (advance && last_pix) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  rect_addr_gen #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .ADDR_W   (ADDR_W),
    .DIM_W    (DIM_W)
  ) u_addr_gen (
    .clock     (clock),
    .resetn    (resetn),
    .load      (load),
    .advance   (advance),
    .x_in      (x),
    .y_in      (y),
    .w_q       (w_q),
    .h_q       (h_q),
    .addr      (addr),
    .pix_valid (pix_valid),
    .last_pix  (last_pix)
  );

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;
  import draw_pkg::*;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int AW = 19;
  localparam int CW = 3;
  localparam int DW = 10;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] x = '0, y = '0, w = '0, h = '0;
  logic [CW-1:0] color = '0;
  logic          mem_ready = 1'b1;
  logic          busy, done, mem_wenable;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_wdata;

  rect_fill_engine dut (
    .clock       (clock),
    .resetn      (resetn),
    .start       (start),
    .x           (x),
    .y           (y),
    .w           (w),
    .h           (h),
    .color       (color),
    .busy        (busy),
    .done        (done),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_wenable (mem_wenable),
    .mem_ready   (mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every presented write must match the queue head;
  // the head is consumed only when the write is accepted, so a stalled
  // write is checked against the same entry each cycle.
  always @(negedge clock) begin
    if (resetn && mon_en) begin
      check("busy_and_done", {63'd0, busy && done}, 64'd0);
      check("wenable_outside_draw", {63'd0, mem_wenable && !busy}, 64'd0);
      if (done) done_cnt++;
      if (mem_wenable) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d, expected no write", mem_waddr);
        end else begin
          check("write_addr", 64'(mem_waddr), 64'(exp_q[0].addr));
          check("write_data", 64'(mem_wdata), 64'(exp_q[0].data));
          if (mem_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_expected(input int x0, input int y0, input int w0, input int h0, input int c0);
    wr_t e;
    for (int r = 0; r < h0; r++) begin
      for (int c = 0; c < w0; c++) begin
`ifdef RECT_FILL_CLIP_EN
        if (x0 + c >= SW || y0 + r >= SH) continue;
`endif
        e.addr = AW'((y0 + r) * SW + x0 + c);
        e.data = CW'(c0);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_fill(input string name, input int x0, input int y0, input int w0,
                          input int h0, input int c0, input int stall_at,
                          input int stall_len, input bit restart);
    int  done_cyc, acc, stl, dcnt0, budget;
    bit  busy_seen;
    push_expected(x0, y0, w0, h0, c0);
    @(posedge clock); #1;
    x = DW'(x0); y = DW'(y0); w = DW'(w0); h = DW'(h0); color = CW'(c0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    dcnt0 = done_cnt;
    done_cyc = -1; acc = 0; stl = 0; busy_seen = 1'b0;
    budget = w0 * h0 + stall_len + 10;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (restart && cyc == 3) begin
        start = 1'b1; x = DW'(100); y = DW'(100); w = DW'(3); h = DW'(3); color = CW'(7);
      end
      if (restart && cyc == 5) start = 1'b0;
      if (mem_wenable && acc == stall_at && stl < stall_len) begin
        mem_ready = 1'b0;
        stl++;
      end else begin
        mem_ready = 1'b1;
      end
      @(negedge clock);
      if (busy) busy_seen = 1'b1;
      if (mem_wenable && mem_ready) acc++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clock); #1;
    end
    mem_ready = 1'b1;
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(w0 * h0 + stall_len + 1));
    check({name, "_busy_seen"}, {63'd0, busy_seen}, {63'd0, (w0 * h0 != 0)});
    @(posedge clock); #1;
    @(negedge clock);
    check({name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
    repeat (3) @(negedge clock);
    check({name, "_done_pulses"}, 64'(done_cnt - dcnt0), 64'd1);
    check({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_wenable", {63'd0, mem_wenable}, 64'd0);
    check("reset_waddr", 64'(mem_waddr), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    resetn = 1'b1;
    mon_en = 1'b1;

    run_fill("basic", 0, 0, 5, 2, 1, -1, 0, 1'b0);
    run_fill("stall", 0, 0, 5, 2, 1, 2, 4, 1'b0);
    run_fill("stall_first", 5, 5, 1, 1, 6, 0, 2, 1'b0);
    run_fill("zero_w", 3, 4, 0, 7, 2, -1, 0, 1'b0);
    run_fill("zero_h", 3, 4, 3, 0, 2, -1, 0, 1'b0);
    run_fill("screen_edge", 638, 479, 4, 2, 7, -1, 0, 1'b0);
    run_fill("addr_wrap", 1000, 1023, 2, 1, 2, -1, 0, 1'b0);
    run_fill("restart_ignored", 10, 20, 4, 3, 4, -1, 0, 1'b1);

    // Asynchronous reset in the middle of a 10x10 fill.
    push_expected(0, 0, 10, 10, 5);
    @(posedge clock); #1;
    x = '0; y = '0; w = DW'(10); h = DW'(10); color = CW'(5);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("midfill_third_addr", 64'(mem_waddr), 64'd2);
    #2 resetn = 1'b0;
    #1;
    check("async_busy", {63'd0, busy}, 64'd0);
    check("async_done", {63'd0, done}, 64'd0);
    check("async_wenable", {63'd0, mem_wenable}, 64'd0);
    check("async_waddr", 64'(mem_waddr), 64'd0);
    check("async_wdata", 64'(mem_wdata), 64'd0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    run_fill("after_reset", 1, 1, 1, 1, 3, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
